cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 8-bit combinational ALU adder.
//  Operands are split into BLOCK-bit lookahead groups, one group per pipeline stage; the inter-group carry is registered.
//  Valid/ready handshake on both sides. Flags C, V, N, Z produced with the sum. Feeds the ALU result mux and the 16-bit address adders.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of BLOCK
//  BLOCK   4  lookahead group width = bits resolved per stage; multiple of 4 when CLA_PIPE_BCD_EN is defined
//  (derived) STAGES = WIDTH/BLOCK = latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat present
//  in_ready   out  1      pipeline accepts a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in (borrow-not when sub=1)
//  sub        in   1      1: compute A + ~B + cin
//  dec        in   1      decimal mode request (see CONFIGURATION)
//  out_valid  out  1      result beat present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of bit WIDTH-1 (decimal: carry out of top digit)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
//  neg        out  1      sum[WIDTH-1]
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Reset: all stage valid bits 0, out_valid=0, sum=0, cout=ovf=neg=zero=0; in-flight beats discarded, no output.
//  - Beat accepted when in_valid && in_ready; ~B and dec/sub latched with it and carried down the pipe.
//  - Stage k (0..STAGES-1) resolves bits [k*BLOCK +: BLOCK] with group generate/propagate lookahead from the registered carry;
//    upper, unprocessed operand bits and lower, finished sum bits travel alongside.
//  - Latency exactly STAGES cycles from acceptance to out_valid when not stalled; throughput 1 beat/cycle.
//  - Stall: adv = !out_valid || out_ready. When adv=0 every stage holds; in_ready = adv (combinational).
//  - A held output (out_valid && !out_ready) keeps sum and flags stable until accepted.
//  - Bubbles propagate; stage registers of invalid slots are don't-care, but outputs must read 0 when out_valid=0 after reset.
//  - Arithmetic is modulo 2^WIDTH; no saturation. Flags always describe the emitted sum.
//  - Simultaneous accept on input and output with a full pipe: both occur, no beat lost or duplicated.
//  - rst asserted together with in_valid: the beat is not accepted.
// CONFIGURATION
//  CLA_PIPE_BCD_EN defined:
//    dec=1 treats operands as packed BCD digits. Add: per-digit binary sum + carry; if >9, add 6 and force digit carry.
//    Sub (sub=1): per-digit A + ~B + carry; if the digit produces no carry, subtract 6 mod 16. Digit carries ripple inside
//    a stage and are registered between stages. Latency unchanged. cout = last digit carry; ovf=0 in decimal mode; N, Z from corrected sum.
//    Non-BCD digits (>9) give an unspecified sum but must not corrupt the handshake.
//  CLA_PIPE_BCD_EN undefined: dec ignored, always binary; no correction logic synthesised.
// TESTING  (WIDTH=16, BLOCK=4, latency 4)
//  - Reset mid-stream with 3 beats in flight -> out_valid stays 0; next accepted beat emerges 4 cycles after acceptance.
//  - a=16'hFFFF, b=16'h0001, cin=0, sub=0 -> sum=16'h0000, cout=1, zero=1, ovf=0, neg=0, at cycle 4.
//  - a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, ovf=1, neg=1, cout=0; a=16'h0005, b=16'h0007, sub=1, cin=1 -> sum=16'hFFFE, cout=0, neg=1.
//  - Back-to-back 100 random beats with out_ready toggled randomly -> results in order, match the reference model, none lost or duplicated.
//  - Full pipe, out_ready=0 for 5 cycles -> in_ready=0, sum held stable; release -> one beat/cycle resumes.
//  - BCD_EN: dec=1 a=16'h0999, b=16'h0001, cin=0 -> sum=16'h1000, cout=0; dec=1 sub=1 a=16'h0000, b=16'h0001, cin=1 -> sum=16'h9999, cout=0.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group is resolved per stage.
// Optional packed-BCD mode (dec=1) is compiled in when CLA_PIPE_BCD_EN is defined.
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);
    localparam int STAGES = WIDTH / BLOCK;

    // One pipeline slot: operands travel with the partially built sum and the inter-group carry.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             c_msb;
`ifdef CLA_PIPE_BCD_EN
        logic             dec;
        logic             sub;
`endif
    } slot_t;

    typedef struct packed {
        logic [BLOCK-1:0] s;
        logic             c;
        logic             c_msb;
    } grp_t;

    function automatic grp_t bin_group(input logic [BLOCK-1:0] ga, input logic [BLOCK-1:0] gb,
                                       input logic gc);
        grp_t             r;
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             gg;
        logic             pp;
        g    = ga & gb;
        p    = ga ^ gb;
        c    = '0;
        c[0] = gc;
        for (int i = 0; i < BLOCK; i++) begin
            gg = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & gc);
        end
        r.s     = p ^ c[BLOCK-1:0];
        r.c     = c[BLOCK];
        r.c_msb = c[BLOCK-1];
        return r;
    endfunction

`ifdef CLA_PIPE_BCD_EN
    // Digit carries ripple inside the group; gb is already ~B when subtracting.
    function automatic grp_t bcd_group(input logic [BLOCK-1:0] ga, input logic [BLOCK-1:0] gb,
                                       input logic gc, input logic gsub);
        grp_t       r;
        logic [4:0] ds;
        logic       dc;
        r  = '0;
        dc = gc;
        for (int d = 0; d < BLOCK / 4; d++) begin
            ds = {1'b0, ga[d*4 +: 4]} + {1'b0, gb[d*4 +: 4]} + {4'b0, dc};
            if (gsub) begin
                dc = ds[4];
                if (!ds[4]) ds[3:0] = ds[3:0] - 4'd6;
            end else if (ds > 5'd9) begin
                ds = ds + 5'd6;
                dc = 1'b1;
            end else begin
                dc = 1'b0;
            end
            r.s[d*4 +: 4] = ds[3:0];
        end
        r.c     = dc;
        r.c_msb = dc;
        return r;
    endfunction
`endif

    slot_t             head;
    slot_t             stage_in [STAGES];
    slot_t             stage_d  [STAGES];
    slot_t             stage_q  [STAGES];
    slot_t             last;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] valid_q;
    logic              adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        head   = '0;
        head.a = a;
        head.b = sub ? ~b : b;
        head.c = cin;
`ifdef CLA_PIPE_BCD_EN
        head.dec = dec;
        head.sub = sub;
`endif
    end

    always_comb begin
        stage_in[0] = head;
        valid_d[0]  = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
            valid_d[k]  = valid_q[k-1];
        end
    end

    // NOTE: blocking assignments in combinational blocks, and every output given a value up front so no latch is inferred.
    always_comb begin
        grp_t grp;
        grp = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_in[k];
            grp = bin_group(stage_in[k].a[k*BLOCK +: BLOCK], stage_in[k].b[k*BLOCK +: BLOCK],
                            stage_in[k].c);
`ifdef CLA_PIPE_BCD_EN
            if (stage_in[k].dec)
                grp = bcd_group(stage_in[k].a[k*BLOCK +: BLOCK], stage_in[k].b[k*BLOCK +: BLOCK],
                                stage_in[k].c, stage_in[k].sub);
`endif
            stage_d[k].s[k*BLOCK +: BLOCK] = grp.s;
            stage_d[k].c                   = grp.c;
            stage_d[k].c_msb               = grp.c_msb;
        end
    end

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
        end
    end

    // NOTE: datapath slots are not reset; their contents are ignored while the matching valid bit is low.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
        end
    end

    assign last      = stage_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = out_valid ? last.s : '0;
    assign cout      = out_valid && last.c;
    assign neg       = sum[WIDTH-1];
    assign zero      = out_valid && (last.s == '0);
`ifdef CLA_PIPE_BCD_EN
    assign ovf = out_valid && !last.dec && (last.c ^ last.c_msb);
`else
    assign ovf = out_valid && (last.c ^ last.c_msb);
    logic dec_unused;
    assign dec_unused = dec;
`endif

    logic [2*WIDTH-1:0] operands_unused;
    assign operands_unused = {last.a, last.b};

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Randomised and directed bench for cla_pipe_adder (WIDTH=16, BLOCK=4, latency 4) with an arithmetic reference model.
module tb_cla_pipe_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        dec;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        neg;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;
    int n_in    = 0;
    int n_out   = 0;

    typedef struct {
        logic [15:0] s;
        logic [3:0]  f;   // {cout, ovf, neg, zero}
    } exp_t;
    exp_t exp_q[$];

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .dec(dec),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .neg(neg), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

`ifdef CLA_PIPE_BCD_EN
    function automatic int bcd2int(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction
`endif

    function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb,
                                   input logic vc, input logic vs, input logic vd);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] bb;
        logic        co;
        logic        ov;
        bb   = vs ? ~vb : vb;
        full = {1'b0, va} + {1'b0, bb} + {16'b0, vc};
        e.s  = full[15:0];
        co   = full[16];
        ov   = (va[15] == bb[15]) && (e.s[15] != va[15]);
`ifdef CLA_PIPE_BCD_EN
        if (vd) begin
            int ad;
            int bd;
            int r;
            ad = bcd2int(va);
            bd = bcd2int(vb);
            if (!vs) begin
                r  = ad + bd + (vc ? 1 : 0);
                co = (r >= 10000);
                r  = r % 10000;
            end else begin
                r  = ad - bd - (vc ? 0 : 1);
                co = (r >= 0);
                if (r < 0) r = r + 10000;
            end
            e.s = int2bcd(r);
            ov  = 1'b0;
        end
`endif
        e.f = {co, ov, e.s[15], e.s == 16'h0};
        return e;
    endfunction

    task automatic observe();
        exp_t e;
        if (rst) begin
            exp_q.delete();
            return;
        end
        if (!out_valid) begin
            check("idle_sum", 32'(sum), 32'h0);
            check("idle_flags", 32'({cout, ovf, neg, zero}), 32'h0);
        end else if (out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_beat", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("flags", 32'({cout, ovf, neg, zero}), 32'(e.f));
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub, dec));
            n_in++;
        end
    endtask

    task automatic tick();
        #1;
        observe();
        @(negedge clk);
    endtask

    task automatic rand_beat();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        dec = 1'($urandom);
`ifdef CLA_PIPE_BCD_EN
        if (dec) begin
            a = int2bcd(int'($urandom_range(0, 9999)));
            b = int2bcd(int'($urandom_range(0, 9999)));
        end
`endif
    endtask

    task automatic single_beat(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input logic vs, input logic vd, input logic [15:0] exp_s,
                               input logic [3:0] exp_f, input string tag);
        bit found;
        a = va; b = vb; cin = vc; sub = vs; dec = vd;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        found    = 1'b0;
        for (int lat = 1; lat <= 20 && !found; lat++) begin
            #1;
            if (out_valid) begin
                found = 1'b1;
                check({tag, "_sum"}, 32'(sum), 32'(exp_s));
                check({tag, "_flags"}, 32'({cout, ovf, neg, zero}), 32'(exp_f));
                check({tag, "_latency"}, 32'(lat), 32'd4);
            end
            observe();
            @(negedge clk);
        end
        if (!found) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int in0;
        int out0;
        int budget;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; dec = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_flags", 32'({cout, ovf, neg, zero}), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        single_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b1001, "wrap");
        single_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 4'b0110, "sovf");
        single_beat(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 4'b0010, "subneg");
`ifdef CLA_PIPE_BCD_EN
        single_beat(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h1000, 4'b0000, "bcd_add");
        single_beat(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h9999, 4'b0010, "bcd_sub");
`else
        single_beat(16'h0999, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h099A, 4'b0000, "dec_ignored");
`endif

        // Reset with three beats in flight; the beat presented alongside rst must not be taken.
        out_ready = 1'b1;
        repeat (3) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rst_flush", 32'(out_valid), 32'h0);
            observe();
            @(negedge clk);
        end
        single_beat(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 4'b0000, "post_rst");

        // Fill the pipe against a stalled consumer, hold, then release.
        out_ready = 1'b0;
        repeat (4) begin
            rand_beat();
            in_valid = 1'b1;
            tick();
        end
        rand_beat();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            if (exp_q.size() > 0) check("stall_sum", 32'(sum), 32'(exp_q[0].s));
            observe();
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            #1;
            check("resume_valid", 32'(out_valid), 32'h1);
            check("resume_in_ready", 32'(in_ready), 32'h1);
            observe();
            @(negedge clk);
        end
        drain();

        // Random traffic with a randomly stalling consumer.
        in0    = n_in;
        out0   = n_out;
        budget = 0;
        while ((n_in - in0) < 100 && budget < 3000) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom);
            tick();
            budget++;
        end
        check("rand_accepted", 32'(n_in - in0), 32'd100);
        drain();
        check("rand_beat_count", 32'(n_out - out0), 32'(n_in - in0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
